// File: rtl/grover_pkg.sv
// Shared definitions for the Grover amplitude register file: default sizes,
// readout FSM states and signed amplitude range helpers.
package grover_pkg;

  localparam int DEF_N_STATES = 8;
  localparam int DEF_AMP_W    = 8;

  typedef enum logic {
    RD_IDLE,
    RD_STREAM
  } rd_state_t;

  // Most-positive and most-negative values of a w-bit two's-complement amplitude.
  function automatic int amp_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int amp_min(input int w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/grover_amp_negate.sv
// Combinational AMP_W-bit two's-complement negation. With SAT_EN set the
// most-negative input clamps to the most-positive value; ovf flags that input.
module grover_amp_negate
  import grover_pkg::*;
#(
  parameter int AMP_W  = DEF_AMP_W,
  parameter bit SAT_EN = 1'b0
) (
  input  logic signed [AMP_W-1:0] a,
  output logic signed [AMP_W-1:0] y,
  output logic                    ovf
);

  localparam logic signed [AMP_W-1:0] AMP_MIN = AMP_W'(amp_min(AMP_W));
  localparam logic signed [AMP_W-1:0] AMP_MAX = AMP_W'(amp_max(AMP_W));

  // Only the most-negative value has no positive counterpart.
  assign ovf = (a == AMP_MIN);
  assign y   = (SAT_EN && ovf) ? AMP_MAX : -a;

endmodule

// File: rtl/grover_state_regfile.sv
// Amplitude register file for the Grover model: bulk load, single write,
// oracle phase flip and a valid/ready readout stream.
// Define GROVER_STATE_SAT_EN for a saturating flip with a sticky sat_flag.
module grover_state_regfile
  import grover_pkg::*;
#(
  parameter int N_STATES = DEF_N_STATES,
  parameter int AMP_W    = DEF_AMP_W,
  parameter int IDX_W    = $clog2(N_STATES)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_en,
  input  logic [N_STATES*AMP_W-1:0] load_data,
  input  logic                      wr_en,
  input  logic [IDX_W-1:0]          wr_idx,
  input  logic signed [AMP_W-1:0]   wr_data,
  input  logic                      flip_en,
  input  logic [IDX_W-1:0]          flip_idx,
  output logic [N_STATES*AMP_W-1:0] amp_out,
  input  logic                      rd_start,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [IDX_W-1:0]          rd_idx,
  output logic signed [AMP_W-1:0]   rd_data,
  output logic                      rd_last,
  output logic                      busy,
  output logic                      sat_flag
);

`ifdef GROVER_STATE_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_STATES - 1);

  logic signed [AMP_W-1:0] amp_q [N_STATES];
  logic signed [AMP_W-1:0] neg_val;
  logic                    neg_ovf;
  logic                    flip_act;
  logic                    sat_q;

  grover_amp_negate #(
    .AMP_W  (AMP_W),
    .SAT_EN (SAT_EN)
  ) u_negate (
    .a   (amp_q[flip_idx]),
    .y   (neg_val),
    .ovf (neg_ovf)
  );

  // A write to the same entry in the same cycle takes precedence over the flip.
  assign flip_act = flip_en && !(wr_en && (wr_idx == flip_idx));

  // NOTE: the entries live in flops, not RAM, so the whole array can be cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_STATES; k++) amp_q[k] <= '0;
    end else if (load_en) begin
      for (int k = 0; k < N_STATES; k++) amp_q[k] <= load_data[k*AMP_W +: AMP_W];
    end else begin
      if (flip_act) amp_q[flip_idx] <= neg_val;
      if (wr_en)    amp_q[wr_idx]   <= wr_data;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                      sat_q <= 1'b0;
    else if (load_en)                             sat_q <= 1'b0;
    else if (SAT_EN && flip_act && neg_ovf)       sat_q <= 1'b1;
  end

  assign sat_flag = SAT_EN ? sat_q : 1'b0;

  always_comb begin
    for (int k = 0; k < N_STATES; k++) amp_out[k*AMP_W +: AMP_W] = amp_q[k];
  end

  rd_state_t        state_q, state_d;
  logic             rd_hs;
  logic [IDX_W-1:0] next_idx;

  assign rd_hs    = rd_valid && rd_ready;
  assign next_idx = rd_idx + 1'b1;

  // NOTE: assigning the default first keeps this block free of inferred latches.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RD_IDLE:   if (rd_start)                       state_d = RD_STREAM;
      RD_STREAM: if (rd_hs && (rd_idx == LAST_IDX))  state_d = RD_IDLE;
      default:                                       state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RD_IDLE;
      rd_valid <= 1'b0;
      rd_idx   <= '0;
      rd_data  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == RD_IDLE) begin
        if (rd_start) begin
          rd_valid <= 1'b1;
          rd_idx   <= '0;
          rd_data  <= amp_q[0];
        end
      end else if (rd_hs) begin
        if (rd_idx == LAST_IDX) begin
          rd_valid <= 1'b0;
        end else begin
          rd_idx  <= next_idx;
          rd_data <= amp_q[next_idx];
        end
      end
    end
  end

  assign busy    = (state_q == RD_STREAM);
  assign rd_last = rd_valid && (rd_idx == LAST_IDX);

endmodule

// File: tb/tb_grover_state_regfile.sv
// Self-checking bench for grover_state_regfile: directed cases plus random
// traffic compared against an array/counter reference model.
module tb_grover_state_regfile;

  localparam int N  = 8;
  localparam int W  = 8;
  localparam int IW = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic                load_en;
  logic [N*W-1:0]      load_data;
  logic                wr_en;
  logic [IW-1:0]       wr_idx;
  logic signed [W-1:0] wr_data;
  logic                flip_en;
  logic [IW-1:0]       flip_idx;
  logic [N*W-1:0]      amp_out;
  logic                rd_start;
  logic                rd_valid;
  logic                rd_ready;
  logic [IW-1:0]       rd_idx;
  logic signed [W-1:0] rd_data;
  logic                rd_last;
  logic                busy;
  logic                sat_flag;

  grover_state_regfile #(.N_STATES(N), .AMP_W(W)) dut (
    .clk(clk), .rst(rst),
    .load_en(load_en), .load_data(load_data),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .flip_en(flip_en), .flip_idx(flip_idx),
    .amp_out(amp_out),
    .rd_start(rd_start), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_idx(rd_idx), .rd_data(rd_data), .rd_last(rd_last),
    .busy(busy), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

`ifdef GROVER_STATE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model: plain integer amplitudes and a beat counter.
  int model [N];
  bit m_sat;
  bit s_busy;
  int s_idx;
  int s_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] pack_model();
    logic [63:0] v = '0;
    for (int k = 0; k < N; k++) v[k*W +: W] = 8'(model[k]);
    return v;
  endfunction

  function automatic int negate_model(input int v);
    if (v == -128) return SAT ? 127 : -128;
    return -v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) model[k] = 0;
    m_sat = 0; s_busy = 0; s_idx = 0; s_data = 0;
  endtask

  // Applies one rising edge to the model using the inputs currently driven.
  task automatic model_clock();
    int old [N];
    old = model;
    if (!s_busy) begin
      if (rd_start) begin s_busy = 1; s_idx = 0; s_data = old[0]; end
    end else if (rd_ready) begin
      if (s_idx == N - 1) s_busy = 0;
      else begin s_idx++; s_data = old[s_idx]; end
    end
    if (load_en) begin
      for (int k = 0; k < N; k++) model[k] = int'($signed(load_data[k*W +: W]));
      m_sat = 0;
    end else begin
      if (flip_en && !(wr_en && wr_idx == flip_idx)) begin
        if (old[flip_idx] == -128 && SAT) m_sat = 1;
        model[flip_idx] = negate_model(old[flip_idx]);
      end
      if (wr_en) model[wr_idx] = int'(wr_data);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_amp"},   64'(amp_out),  pack_model());
    check({tag, "_valid"}, 64'(rd_valid), 64'(s_busy));
    check({tag, "_busy"},  64'(busy),     64'(s_busy));
    check({tag, "_last"},  64'(rd_last),  64'(s_busy && s_idx == N - 1));
    check({tag, "_sat"},   64'(sat_flag), 64'(m_sat));
    if (s_busy) begin
      check({tag, "_ridx"},  64'(rd_idx),  64'(s_idx));
      check({tag, "_rdata"}, 64'(rd_data), 64'(8'(s_data)));
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_clock();
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    load_en = 0; wr_en = 0; flip_en = 0; rd_start = 0;
  endtask

  int q_idx [$];
  int b2_data, b4_data, old2;

  initial begin
    rst = 1; idle_inputs(); rd_ready = 0;
    load_data = '0; wr_idx = '0; wr_data = '0; flip_idx = '0;
    model_reset();
    #2;
    check_all("reset");
    @(negedge clk); rst = 0;

    // Bulk load: entry k = k.
    for (int k = 0; k < N; k++) load_data[k*W +: W] = 8'(k);
    load_en = 1;
    step("load");
    idle_inputs();
    check("load_e7", 64'(amp_out[7*W +: W]), 64'd7);

    // Write and flip on different entries, then on the same entry.
    wr_en = 1; wr_idx = 3; wr_data = -8'sd5; flip_en = 1; flip_idx = 5;
    step("wr_flip_diff");
    check("diff_e5", 64'(amp_out[5*W +: W]), 64'(8'hFB));
    wr_idx = 2; wr_data = 8'sd33; flip_idx = 2;
    step("wr_flip_same");
    check("same_e2", 64'(amp_out[2*W +: W]), 64'(8'd33));
    idle_inputs();

    // Most-negative flip, a second flip, then a load that clears sat_flag.
    wr_en = 1; wr_idx = 1; wr_data = -8'sd128;
    step("wr_min");
    wr_en = 0; flip_en = 1; flip_idx = 1;
    step("flip_min");
    check("flip_min_val", 64'(amp_out[1*W +: W]), SAT ? 64'h7F : 64'h80);
    check("flip_min_sat", 64'(sat_flag), 64'(SAT));
    step("flip_again");
    idle_inputs(); load_en = 1;
    step("load_clr");
    check("sat_cleared", 64'(sat_flag), 64'd0);
    idle_inputs();

    // Back-pressured stream with a stray rd_start while busy.
    rd_start = 1; rd_ready = 0;
    step("bp_start");
    rd_start = 0;
    q_idx.delete();
    for (int c = 0; c < 40 && s_busy; c++) begin
      rd_ready = c[0];
      rd_start = (c == 3);
      if (rd_valid && rd_ready) q_idx.push_back(int'(rd_idx));
      step("bp_stream");
    end
    idle_inputs(); rd_ready = 0;
    check("bp_beats", 64'(q_idx.size()), 64'(N));
    for (int k = 0; k < q_idx.size(); k++) check("bp_order", 64'(q_idx[k]), 64'(k));
    step("bp_idle");

    // Snapshot: stall on beat 2 while writing entries 2 and 4.
    old2 = model[2];
    rd_start = 1; rd_ready = 1;
    step("snap_start");
    rd_start = 0;
    for (int c = 0; c < 10 && s_idx != 2; c++) step("snap_adv");
    rd_ready = 0; rd_start = 1;
    wr_en = 1; wr_idx = 2; wr_data = 8'sd99;
    step("snap_w2");
    wr_idx = 4; wr_data = 8'sd42;
    step("snap_w4");
    wr_en = 0; rd_start = 0;
    b2_data = int'(rd_data);
    rd_ready = 1;
    step("snap_b3");
    step("snap_b4");
    b4_data = int'(rd_data);
    check("snap_beat2_old", 64'(8'(b2_data)), 64'(8'(old2)));
    check("snap_beat4_new", 64'(8'(b4_data)), 64'(8'd42));
    for (int c = 0; c < 10 && s_busy; c++) step("snap_drain");
    check("snap_done", 64'(busy), 64'd0);

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      load_en  = ($urandom_range(0, 15) == 0);
      for (int k = 0; k < N; k++) load_data[k*W +: W] = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom);
      wr_en    = ($urandom_range(0, 2) == 0);
      wr_idx   = IW'($urandom);
      wr_data  = ($urandom_range(0, 5) == 0) ? -8'sd128 : 8'($urandom);
      flip_en  = ($urandom_range(0, 1) == 0);
      flip_idx = IW'($urandom);
      rd_start = ($urandom_range(0, 3) == 0);
      rd_ready = ($urandom_range(0, 2) != 0);
      step("rand");
    end
    idle_inputs(); rd_ready = 0;

    // Reset in the middle of a stream.
    rd_start = 1; rd_ready = 1;
    step("mr_start");
    rd_start = 0;
    for (int c = 0; c < 10 && s_idx != 3; c++) step("mr_adv");
    rst = 1;
    #1;
    model_reset();
    check_all("mr_reset");
    @(negedge clk); rst = 0;
    rd_start = 1; rd_ready = 0;
    step("mr_restart");
    check("mr_idx0", 64'(rd_idx), 64'd0);
    idle_inputs();
    step("mr_tail");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=0", checks);
    $fatal(1, "timeout");
  end

endmodule
